sonic_rx_block_sync_66: RTL and testbench
=========================================

SONIC_RX_BLOCK_SYNC_66 -- requirements
Module: sonic_rx_block_sync_66

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- LOCK_CNT, 64: consecutive valid headers to lock, and bad-header window length when locked.
- BAD_SH_MAX, 16: bad headers within one window that drop lock.
- SLIP_WAIT, 32: valid words ignored after each slip.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clock, in, 1: single clock; the gearbox output clock, which is also the write clock of the rx buffer controller.
- reset_n, in, 1: asynchronous, active-low reset.
- enable, in, 1: enable_sfp and xcvr_ready.
- data_valid, in, 1: gearbox 66-bit word valid.
- data_in, in, 66: gearbox word; sync header is data_in[1:0].
- data_out, out, 66: registered copy of data_in.
- wrreq, out, 1: write request to the rx buffer controller.
- block_lock, out, 1: block lock achieved.
- slip, out, 1: one-cycle bit-slip request to the gearbox.
- sh_err_cnt, out, 16: saturating count of bad headers seen while locked.

Function
REQ-003 A header SHALL be good when data_in[1:0] is 2'b01 or 2'b10, and bad when it is 2'b00 or 2'b11; it is evaluated only on cycles with data_valid=1.
REQ-004 The FSM SHALL have three states: HUNT, SLIP_HOLD and LOCKED. The reset state is HUNT.
REQ-005 HUNT, good header: good_cnt SHALL increment. When the word makes LOCK_CNT consecutive good headers, the next state SHALL be LOCKED, block_lock SHALL be 1 from the next cycle, and both counters SHALL clear.
REQ-006 HUNT, bad header: slip SHALL be 1 for exactly the next cycle, good_cnt SHALL clear, and the next state SHALL be SLIP_HOLD.
REQ-007 SLIP_HOLD: the block SHALL count SLIP_WAIT valid words, ignoring their headers, then enter HUNT with good_cnt=0. slip SHALL stay 0 throughout.
REQ-008 LOCKED: every valid word SHALL increment win_cnt, and every bad header SHALL increment bad_cnt.
REQ-009 LOCKED, loss of lock: when bad_cnt reaches BAD_SH_MAX within the window, on that word:
- block_lock SHALL deassert next cycle.
- slip SHALL pulse next cycle.
- the next state SHALL be SLIP_HOLD and the counters SHALL clear.
REQ-010 LOCKED, end of window: when win_cnt completes LOCK_CNT words with bad_cnt < BAD_SH_MAX, both counters SHALL clear and the state SHALL remain LOCKED. A bad header on the final word of a window SHALL be counted before the BAD_SH_MAX comparison.
REQ-011 enable=0 SHALL, on the next clock:
- force HUNT with all counters cleared.
- set block_lock=0, slip=0 and wrreq=0.
enable has priority over every other transition.
REQ-012 data_out SHALL register data_in on every cycle with data_valid=1 and hold otherwise. Latency is 1 cycle.
REQ-013 wrreq SHALL be 1 in the cycle after a valid word accepted while state=LOCKED and enable=1, including bad-header words that do not cause loss of lock. It SHALL be 0 for the word that completes lock and for the word that causes loss of lock.
REQ-014 sh_err_cnt SHALL increment on every bad header in LOCKED and saturate at 16'hFFFF. It SHALL clear only on reset.
REQ-015 Counter widths SHALL be $clog2(LOCK_CNT+1) for good_cnt and win_cnt, $clog2(BAD_SH_MAX+1) for bad_cnt, and $clog2(SLIP_WAIT+1) for the hold counter. No counter SHALL wrap.
REQ-016 data_valid=0 cycles SHALL leave all counters and the state unchanged, and SHALL produce wrreq=0 and slip=0.

Reset
REQ-017 reset_n=0 SHALL immediately and asynchronously set:
- state=HUNT and all counters=0.
- data_out=66'h0, wrreq=0, block_lock=0, slip=0, sh_err_cnt=0.
REQ-018 Reset mid-lock or mid-hold SHALL discard all progress. After release, lock SHALL require a fresh LOCK_CNT good headers.

Verification
REQ-019 Lock acquisition: enable=1, 64 consecutive valid words with header 2'b01, then more words.
- Expected: block_lock=1 one cycle after word 64.
- Expected: wrreq=1 first for word 65, with data_out equal to word 65 one cycle later.
REQ-020 Hunt slip: word 10 has header 2'b11 while in HUNT.
- Expected: slip=1 for one cycle; block_lock stays 0.
- Expected: 32 further valid words are ignored, then 64 good headers are needed to lock.
REQ-021 Loss of lock: locked, then 16 headers of 2'b00 within one 64-word window.
- Expected: block_lock=0 and a slip pulse the cycle after the 16th bad header.
- Expected: sh_err_cnt=16 and no wrreq for the 16th word.
REQ-022 Window boundary: locked, 15 bad headers per window over 4 consecutive windows.
- Expected: lock held, sh_err_cnt=60, and wrreq asserted for all 256 words.
REQ-023 Gapped input and enable drop: locked with data_valid toggling 1/0.
- Expected: wrreq and window counting follow valid words only.
- Expected: enable=0 for 1 cycle gives block_lock=0 next cycle and HUNT.
REQ-024 Async reset: assert reset_n=0 mid-window between clock edges.
- Expected: all outputs go to 0 without waiting for a clock edge.
- Expected: after release, a full 64-word relock is needed.

Source files
------------

// File: rtl/sonic_rx_block_sync_66.sv
// 64b/66b receive block synchronizer: hunts for sync-header lock, slips the gearbox
// on bad headers, and monitors header errors while locked.
module sonic_rx_block_sync_66 #(
    parameter int unsigned LOCK_CNT   = 64,
    parameter int unsigned BAD_SH_MAX = 16,
    parameter int unsigned SLIP_WAIT  = 32
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        data_valid,
    input  logic [65:0] data_in,
    output logic [65:0] data_out,
    output logic        wrreq,
    output logic        block_lock,
    output logic        slip,
    output logic [15:0] sh_err_cnt
);

    localparam int unsigned GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned WIN_W  = $clog2(LOCK_CNT + 1);
    localparam int unsigned BAD_W  = $clog2(BAD_SH_MAX + 1);
    localparam int unsigned HOLD_W = $clog2(SLIP_WAIT + 1);

    localparam logic [1:0] ST_HUNT      = 2'd0;
    localparam logic [1:0] ST_SLIP_HOLD = 2'd1;
    localparam logic [1:0] ST_LOCKED    = 2'd2;

    logic [1:0]        r_state;
    logic [GOOD_W-1:0] r_good_cnt;
    logic [WIN_W-1:0]  r_win_cnt;
    logic [BAD_W-1:0]  r_bad_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [65:0]       r_data_out;
    logic              r_wrreq;
    logic              r_block_lock;
    logic              r_slip;
    logic [15:0]       r_sh_err_cnt;

    logic [1:0]        w_state_nxt;
    logic [GOOD_W-1:0] w_good_nxt;
    logic [WIN_W-1:0]  w_win_nxt;
    logic [BAD_W-1:0]  w_bad_nxt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              w_slip_nxt;
    logic              w_wrreq_nxt;
    logic              w_err_inc;
    logic              w_sh_bad;
    logic [WIN_W-1:0]  w_win_sum;
    logic [BAD_W-1:0]  w_bad_sum;

    // A header is good only when its two bits differ (01 or 10)
    assign w_sh_bad  = ~(data_in[1] ^ data_in[0]);
    assign w_win_sum = r_win_cnt + WIN_W'(1);
    assign w_bad_sum = r_bad_cnt + BAD_W'(w_sh_bad);

    // Next-state, counter and output-request logic
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        w_win_nxt   = r_win_cnt;
        w_bad_nxt   = r_bad_cnt;
        w_hold_nxt  = r_hold_cnt;
        w_slip_nxt  = 1'b0;
        w_wrreq_nxt = 1'b0;
        w_err_inc   = 1'b0;

        if (!enable) begin
            w_state_nxt = ST_HUNT;
            w_good_nxt  = '0;
            w_win_nxt   = '0;
            w_bad_nxt   = '0;
            w_hold_nxt  = '0;
        end else if (data_valid) begin
            case (r_state)
                ST_HUNT: begin
                    if (w_sh_bad) begin
                        w_slip_nxt  = 1'b1;
                        w_good_nxt  = '0;
                        w_hold_nxt  = '0;
                        w_state_nxt = ST_SLIP_HOLD;
                    end else if (r_good_cnt == GOOD_W'(LOCK_CNT - 1)) begin
                        w_good_nxt  = '0;
                        w_win_nxt   = '0;
                        w_bad_nxt   = '0;
                        w_state_nxt = ST_LOCKED;
                    end else begin
                        w_good_nxt = r_good_cnt + GOOD_W'(1);
                    end
                end
                ST_SLIP_HOLD: begin
                    if (r_hold_cnt == HOLD_W'(SLIP_WAIT - 1)) begin
                        w_hold_nxt  = '0;
                        w_good_nxt  = '0;
                        w_state_nxt = ST_HUNT;
                    end else begin
                        w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                    end
                end
                ST_LOCKED: begin
                    w_err_inc = w_sh_bad;
                    // The current word's header is folded in before the threshold test
                    if (w_bad_sum == BAD_W'(BAD_SH_MAX)) begin
                        w_slip_nxt  = 1'b1;
                        w_win_nxt   = '0;
                        w_bad_nxt   = '0;
                        w_hold_nxt  = '0;
                        w_state_nxt = ST_SLIP_HOLD;
                    end else if (w_win_sum == WIN_W'(LOCK_CNT)) begin
                        w_wrreq_nxt = 1'b1;
                        w_win_nxt   = '0;
                        w_bad_nxt   = '0;
                    end else begin
                        w_wrreq_nxt = 1'b1;
                        w_win_nxt   = w_win_sum;
                        w_bad_nxt   = w_bad_sum;
                    end
                end
                default: begin
                    w_state_nxt = ST_HUNT;
                    w_good_nxt  = '0;
                    w_win_nxt   = '0;
                    w_bad_nxt   = '0;
                    w_hold_nxt  = '0;
                end
            endcase
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_HUNT;
            r_good_cnt   <= '0;
            r_win_cnt    <= '0;
            r_bad_cnt    <= '0;
            r_hold_cnt   <= '0;
            r_data_out   <= '0;
            r_wrreq      <= 1'b0;
            r_block_lock <= 1'b0;
            r_slip       <= 1'b0;
            r_sh_err_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_good_cnt   <= w_good_nxt;
            r_win_cnt    <= w_win_nxt;
            r_bad_cnt    <= w_bad_nxt;
            r_hold_cnt   <= w_hold_nxt;
            r_wrreq      <= w_wrreq_nxt;
            r_block_lock <= (w_state_nxt == ST_LOCKED);
            r_slip       <= w_slip_nxt;
            if (data_valid) begin
                r_data_out <= data_in;
            end
            if (w_err_inc && (r_sh_err_cnt != 16'hFFFF)) begin
                r_sh_err_cnt <= r_sh_err_cnt + 16'd1;
            end
        end
    end

    assign data_out   = r_data_out;
    assign wrreq      = r_wrreq;
    assign block_lock = r_block_lock;
    assign slip       = r_slip;
    assign sh_err_cnt = r_sh_err_cnt;

endmodule

// File: tb/tb_sonic_rx_block_sync_66.sv
// Directed, table-driven bench for sonic_rx_block_sync_66: lock, slips, windows,
// gapped input, enable drop and asynchronous reset.
module tb_sonic_rx_block_sync_66;

    typedef struct {
        logic        en;
        logic        vld;
        logic [65:0] din;
        logic        exp_lock;
        logic        exp_slip;
        logic        exp_wr;
        logic [65:0] exp_dout;
        logic [15:0] exp_err;
    } vec_t;

    logic        clock;
    logic        reset_n;
    logic        enable;
    logic        data_valid;
    logic [65:0] data_in;
    logic [65:0] data_out;
    logic        wrreq;
    logic        block_lock;
    logic        slip;
    logic [15:0] sh_err_cnt;

    int n_checks;
    int n_errors;

    vec_t        vq[$];
    logic [63:0] b_payload;
    logic [65:0] b_last_dout;
    logic [15:0] b_err;

    sonic_rx_block_sync_66 dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .data_valid (data_valid),
        .data_in    (data_in),
        .data_out   (data_out),
        .wrreq      (wrreq),
        .block_lock (block_lock),
        .slip       (slip),
        .sh_err_cnt (sh_err_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int idx, input logic [65:0] act, input logic [65:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s vec %0d got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Append one cycle: inputs plus the outputs expected right after the next clock edge
    task automatic add(input logic en, input logic vld, input logic [1:0] hdr,
                       input logic lock, input logic slp, input logic wr);
        vec_t v;
        b_payload = b_payload + 64'd1;
        v.en  = en;
        v.vld = vld;
        v.din = {b_payload, hdr};
        if (vld) b_last_dout = v.din;
        v.exp_lock = lock;
        v.exp_slip = slp;
        v.exp_wr   = wr;
        v.exp_dout = b_last_dout;
        v.exp_err  = b_err;
        vq.push_back(v);
    endtask

    task automatic run_table();
        foreach (vq[i]) begin
            @(negedge clock);
            enable     = vq[i].en;
            data_valid = vq[i].vld;
            data_in    = vq[i].din;
            @(posedge clock);
            #1;
            chk("block_lock", i, 66'(block_lock), 66'(vq[i].exp_lock));
            chk("slip",       i, 66'(slip),       66'(vq[i].exp_slip));
            chk("wrreq",      i, 66'(wrreq),      66'(vq[i].exp_wr));
            chk("data_out",   i, data_out,        vq[i].exp_dout);
            chk("sh_err_cnt", i, 66'(sh_err_cnt), 66'(vq[i].exp_err));
        end
        vq.delete();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_lock"}, 0, 66'(block_lock), 66'd0);
        chk({name, "_slip"}, 0, 66'(slip),       66'd0);
        chk({name, "_wr"},   0, 66'(wrreq),      66'd0);
        chk({name, "_dout"}, 0, data_out,        66'd0);
        chk({name, "_err"},  0, 66'(sh_err_cnt), 66'd0);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        b_payload   = 64'h0;
        b_last_dout = 66'h0;
        b_err       = 16'd0;
        reset_n     = 1'b0;
        enable      = 1'b0;
        data_valid  = 1'b0;
        data_in     = 66'h0;

        #12;
        chk_all_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;

        // Lock acquisition: 64 good headers, lock visible after word 64
        for (int k = 1; k <= 64; k++) add(1'b1, 1'b1, (k % 2 == 1) ? 2'b01 : 2'b10, k == 64, 1'b0, 1'b0);
        // Four windows, 15 bad headers each at the window tail (including the final word)
        for (int w = 0; w < 4; w++) begin
            for (int k = 1; k <= 64; k++) begin
                if (k >= 50) b_err = b_err + 16'd1;
                add(1'b1, 1'b1, (k >= 50) ? 2'b00 : 2'b01, 1'b1, 1'b0, 1'b1);
            end
        end
        // Loss of lock: 16 bad headers at the start of a fresh window
        for (int k = 1; k <= 16; k++) begin
            b_err = b_err + 16'd1;
            add(1'b1, 1'b1, 2'b00, k < 16, k == 16, k < 16);
        end
        // Slip hold: 32 valid words with bad headers ignored, one gap inside
        for (int k = 1; k <= 32; k++) begin
            add(1'b1, 1'b1, (k % 2 == 1) ? 2'b11 : 2'b00, 1'b0, 1'b0, 1'b0);
            if (k == 16) add(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0);
        end
        // Hunt slip on word 10
        for (int k = 1; k <= 9; k++) add(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 2'b11, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 32; k++) add(1'b1, 1'b1, (k % 2 == 1) ? 2'b00 : 2'b11, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 64; k++) add(1'b1, 1'b1, 2'b10, k == 64, 1'b0, 1'b0);
        // Gapped input: bad headers on invalid cycles are ignored; 16th valid bad drops lock
        for (int v = 1; v <= 40; v++) begin
            if (v >= 25) b_err = b_err + 16'd1;
            add(1'b1, 1'b1, (v >= 25) ? 2'b00 : 2'b01, v < 40, v == 40, v < 40);
            if (v < 40) add(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        end
        for (int k = 1; k <= 32; k++) add(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 64; k++) add(1'b1, 1'b1, 2'b01, k == 64, 1'b0, 1'b0);
        for (int k = 1; k <= 3; k++) add(1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
        // Enable drop while locked, then again part-way through a hunt
        add(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 30; k++) add(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 64; k++) add(1'b1, 1'b1, 2'b10, k == 64, 1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) add(1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
        run_table();

        // Asynchronous reset mid-window, between clock edges
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        data_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        // Fresh 64-word relock required after reset
        b_last_dout = 66'h0;
        b_err       = 16'd0;
        for (int k = 1; k <= 64; k++) add(1'b1, 1'b1, 2'b01, k == 64, 1'b0, 1'b0);
        add(1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1);
        run_table();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
